ddr3_port_arbiter: RTL and testbench
====================================

# ddr3_port_arbiter

Two-port arbiter that shares the single DDR3 controller local user interface between two requesters: port 0 is the PCIe-side data mover and port 1 is the DDR3 data exerciser. It sits between those requesters and the controller, runs in the controller's `sclk` domain, and gates all traffic until `init_done`. It serves one transaction at a time with round-robin fairness, steers write data from the granted port, routes read data back to that port, and recovers from lost read data with a watchdog.

## Interface
- `TIMEOUT_CYCLES`, 1024: read-data watchdog limit in clocks; minimum 16.
- `clk`  in  1  controller `sclk`; single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `init_done`  in  1  controller initialisation complete.
- `pN_cmd_valid`  in  1  (N=0,1) port N requests a transaction; it holds this and all command fields stable until `pN_cmd_ack`.
- `pN_cmd`  in  4  port N command code.
- `pN_addr`  in  26  port N address.
- `pN_burst_cnt`  in  5  port N 64-bit word count; 1..31 as given, 0 means 32.
- `pN_write_data`  in  64  port N write word.
- `pN_data_mask`  in  8  port N write byte mask.
- `pN_cmd_ack`  out  1  one-cycle pulse: port N command accepted by the controller.
- `pN_datain_rdy`  out  1  port N write word consumed this cycle.
- `pN_read_data`  out  64  read word, broadcast to both ports.
- `pN_read_data_valid`  out  1  read word belongs to port N.
- `pN_done`  out  1  one-cycle pulse: port N transaction finished.
- `cmd_rdy`, `datain_rdy`, `read_data_valid`  in  1  from controller.
- `read_data`  in  64  from controller.
- `cmd_valid`  out  1  to controller.
- `cmd`  out  4  to controller.
- `addr`  out  26  to controller.
- `cmd_burst_cnt`  out  5  to controller.
- `write_data`  out  64  to controller.
- `data_mask`  out  8  to controller.
- `grant`  out  1  index of the port currently owning the controller.
- `busy`  out  1  state is not IDLE.
- `timeout_err`  out  1  sticky read-watchdog error flag; cleared only by `rst`.

## Operation
- Command classes:
  - READ (4'h1) and READA (4'h3) are reads.
  - WRITE (4'h2) and WRITEA (4'h4) are writes.
  - All other codes are control commands; they are passed through with no data phase.
- States are IDLE, CMD, WDATA, RDATA and DONE.
- IDLE:
  - Arbitration happens only while `init_done`=1.
  - With exactly one request, that port wins.
  - With both requesting, the port not last granted wins. The last-granted pointer resets so that port 0 wins first.
  - On a win: `pN` fields are latched into `cmd`/`addr`/`cmd_burst_cnt`, `grant` is set, and the state moves to CMD.
- CMD:
  - `cmd_valid`=1; acceptance is the cycle where `cmd_valid`&&`cmd_rdy`.
  - The cycle after acceptance, `cmd_valid` drops and `pN_cmd_ack` pulses.
  - The next state is WDATA, RDATA or DONE according to the command class.
  - The word counter is loaded with the burst count, with 0 mapping to 32.
- WDATA:
  - `write_data`/`data_mask` are combinationally muxed from the granted port.
  - Each `datain_rdy` cycle asserts `pN_datain_rdy` in the same cycle and decrements the counter.
  - The last word moves the state to DONE.
- RDATA:
  - `read_data` is broadcast to both ports.
  - `read_data_valid` is copied to `pN_read_data_valid` of the granted port only, in the same cycle; each such cycle decrements the counter.
  - The last word moves the state to DONE.
  - The watchdog counts cycles without `read_data_valid` and restarts on every valid word. On reaching `TIMEOUT_CYCLES` it sets `timeout_err` and moves to DONE.
- DONE:
  - `pN_done` pulses for one cycle, the last-granted pointer is updated, and the state returns to IDLE.
- Stray `datain_rdy` or `read_data_valid` outside its owning state is ignored and never forwarded.
- `init_done` falling while not in IDLE does not abort the transaction in progress; it only blocks the next arbitration.

## Timing
- Reset values: all outputs 0 (`cmd_valid`, all acks/dones/valids, `grant`, `busy`, `timeout_err`, the counters); state is IDLE.
- Request to `cmd_valid`:
  - Request sampled in cycle T, `cmd_valid` high in T+1.
  - With `cmd_rdy` held high, acceptance is in T+1 and `pN_cmd_ack` pulses in T+2.
- Control command: `pN_done` at T+3 (one clock in DONE after the ack cycle); IDLE again at T+4.
- Throughput: at least one idle cycle in IDLE between transactions. A back-to-back request from the other port is granted in the IDLE cycle.
- `rst` mid-transaction: return to IDLE in the next cycle with `cmd_valid` low; any partial burst is abandoned.
- Data-path forwarding adds zero latency; the only combinational paths are the data muxes and the valid/ready steering.

## Structure
- Package `ddr3_arb_pkg` holds:
  - the command codes (CMD_READ, CMD_WRITE, CMD_READA, CMD_WRITEA);
  - the state encoding;
  - the widths (ADDR_W=26, DATA_W=64, MASK_W=8, BCNT_W=5).
- Sub-module `rr_arb2`: two-request round-robin picker with a last-grant register and an update strobe. It is reusable by the other shared-resource blocks.
- The datapath muxes and the FSM stay in the top module.

## Test plan
- Reset, then `init_done`=0 with `p0_cmd_valid`=1 → `cmd_valid` stays 0. After `init_done` rises, `cmd_valid`=1 one cycle later with `addr`=`p0_addr`.
- Port 0 write: WRITE, `burst_cnt`=4, `datain_rdy` on alternate cycles → exactly 4 `p0_datain_rdy` pulses, `write_data` = port 0 data each beat, `p0_done` after the 4th beat, `p1` outputs stay 0.
- Both ports request READ together, twice → grants are 0, 1, 0, 1. `read_data_valid` reaches only the granted port, with 8 words each for `burst_cnt`=8.
- `burst_cnt`=0 read → 32 words are forwarded before `p0_done`; a 33rd stray valid word is not forwarded.
- Read with only 2 of 4 words returned, `TIMEOUT_CYCLES`=16 → `timeout_err`=1 sixteen cycles after the 2nd word, `p0_done` pulses, and the arbiter is back in IDLE and serves `p1`.
- `rst` asserted mid-WDATA → all outputs are 0 the next cycle and a fresh port 1 request is granted normally.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the DDR3 two-port arbiter: command codes, FSM
// encoding, bus widths and small command-decoding helpers.
package ddr3_arb_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int BCNT_W = 5;
  localparam int CMD_W  = 4;
  localparam int WCNT_W = BCNT_W + 1;

  localparam logic [CMD_W-1:0] CMD_READ   = 4'h1;
  localparam logic [CMD_W-1:0] CMD_WRITE  = 4'h2;
  localparam logic [CMD_W-1:0] CMD_READA  = 4'h3;
  localparam logic [CMD_W-1:0] CMD_WRITEA = 4'h4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_CTRL  = 2'd0,
    CLS_READ  = 2'd1,
    CLS_WRITE = 2'd2
  } cmd_class_t;

  function automatic cmd_class_t cmd_class(input logic [CMD_W-1:0] c);
    cmd_class_t cls;
    case (c)
      CMD_READ, CMD_READA:   cls = CLS_READ;
      CMD_WRITE, CMD_WRITEA: cls = CLS_WRITE;
      default:               cls = CLS_CTRL;
    endcase
    return cls;
  endfunction

  // A zero burst count encodes the maximum burst of 32 words.
  function automatic logic [WCNT_W-1:0] burst_words(input logic [BCNT_W-1:0] b);
    return (b == '0) ? WCNT_W'(32) : {1'b0, b};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. When both request, the one not recorded
// as last granted wins; the record changes only on the update strobe.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_idx,
  output logic       pick,
  output logic       any
);

  logic last;

  // Reset to 1 so that requester 0 wins the first contested round.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (update) begin
      last <= update_idx;
    end
  end

  always_comb begin
    any  = |req;
    pick = req[1];
    if (req == 2'b11) begin
      pick = ~last;
    end
  end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Shares the DDR3 controller user interface between two requesters, one
// transaction at a time, with round-robin fairness and a read watchdog.
module ddr3_port_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              p0_cmd_valid,
  input  logic [CMD_W-1:0]  p0_cmd,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [BCNT_W-1:0] p0_burst_cnt,
  input  logic [DATA_W-1:0] p0_write_data,
  input  logic [MASK_W-1:0] p0_data_mask,
  output logic              p0_cmd_ack,
  output logic              p0_datain_rdy,
  output logic [DATA_W-1:0] p0_read_data,
  output logic              p0_read_data_valid,
  output logic              p0_done,
  input  logic              p1_cmd_valid,
  input  logic [CMD_W-1:0]  p1_cmd,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [BCNT_W-1:0] p1_burst_cnt,
  input  logic [DATA_W-1:0] p1_write_data,
  input  logic [MASK_W-1:0] p1_data_mask,
  output logic              p1_cmd_ack,
  output logic              p1_datain_rdy,
  output logic [DATA_W-1:0] p1_read_data,
  output logic              p1_read_data_valid,
  output logic              p1_done,
  input  logic              cmd_rdy,
  input  logic              datain_rdy,
  input  logic              read_data_valid,
  input  logic [DATA_W-1:0] read_data,
  output logic              cmd_valid,
  output logic [CMD_W-1:0]  cmd,
  output logic [ADDR_W-1:0] addr,
  output logic [BCNT_W-1:0] cmd_burst_cnt,
  output logic [DATA_W-1:0] write_data,
  output logic [MASK_W-1:0] data_mask,
  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t            state, state_n;
  logic              accepted;
  logic [WCNT_W-1:0] wcnt;
  logic [WD_W-1:0]   wd;
  logic              arb_pick, arb_any, arb_go, wd_expire;

  rr_arb2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        ({p1_cmd_valid, p0_cmd_valid}),
    .update     (state == ST_DONE),
    .update_idx (grant),
    .pick       (arb_pick),
    .any        (arb_any)
  );

  always_comb begin
    arb_go    = (state == ST_IDLE) && init_done && arb_any;
    // wd holds cycles elapsed since the last word; expiry lands the flag
    // exactly TIMEOUT_CYCLES cycles after that word.
    wd_expire = (state == ST_RDATA) && !read_data_valid &&
                (wd == WD_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (arb_go) state_n = ST_CMD;
      ST_CMD: begin
        if (accepted) begin
          case (cmd_class(cmd))
            CLS_READ:  state_n = ST_RDATA;
            CLS_WRITE: state_n = ST_WDATA;
            default:   state_n = ST_DONE;
          endcase
        end
      end
      ST_WDATA: if (datain_rdy && wcnt == WCNT_W'(1)) state_n = ST_DONE;
      ST_RDATA: begin
        if ((read_data_valid && wcnt == WCNT_W'(1)) || wd_expire) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid          = 1'b0;
    p0_cmd_ack         = 1'b0;
    p1_cmd_ack         = 1'b0;
    p0_datain_rdy      = 1'b0;
    p1_datain_rdy      = 1'b0;
    p0_read_data_valid = 1'b0;
    p1_read_data_valid = 1'b0;
    p0_done            = 1'b0;
    p1_done            = 1'b0;
    write_data         = '0;
    data_mask          = '0;
    busy               = (state != ST_IDLE);
    case (state)
      ST_CMD: begin
        cmd_valid  = !accepted;
        p0_cmd_ack = accepted && !grant;
        p1_cmd_ack = accepted && grant;
      end
      ST_WDATA: begin
        write_data    = grant ? p1_write_data : p0_write_data;
        data_mask     = grant ? p1_data_mask : p0_data_mask;
        p0_datain_rdy = datain_rdy && !grant;
        p1_datain_rdy = datain_rdy && grant;
      end
      ST_RDATA: begin
        p0_read_data_valid = read_data_valid && !grant;
        p1_read_data_valid = read_data_valid && grant;
      end
      ST_DONE: begin
        p0_done = !grant;
        p1_done = grant;
      end
      default: ;
    endcase
  end

  assign p0_read_data = read_data;
  assign p1_read_data = read_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted      <= 1'b0;
      grant         <= 1'b0;
      cmd           <= '0;
      addr          <= '0;
      cmd_burst_cnt <= '0;
      wcnt          <= '0;
      wd            <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          accepted <= 1'b0;
          if (arb_go) begin
            grant         <= arb_pick;
            cmd           <= arb_pick ? p1_cmd : p0_cmd;
            addr          <= arb_pick ? p1_addr : p0_addr;
            cmd_burst_cnt <= arb_pick ? p1_burst_cnt : p0_burst_cnt;
          end
        end
        ST_CMD: begin
          if (cmd_valid && cmd_rdy) accepted <= 1'b1;
          if (accepted) begin
            wcnt <= burst_words(cmd_burst_cnt);
            wd   <= WD_W'(1);
          end
        end
        ST_WDATA: begin
          if (datain_rdy) wcnt <= wcnt - 1'b1;
        end
        ST_RDATA: begin
          if (read_data_valid) begin
            wcnt <= wcnt - 1'b1;
            wd   <= WD_W'(1);
          end else begin
            wd <= wd + 1'b1;
          end
          if (wd_expire) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: a cycle table for a port-0 write
// plus hand-written read, watchdog and reset sequences.
module tb_ddr3_port_arbiter;

  localparam logic [25:0] A0  = 26'h2ABCDEF;
  localparam logic [25:0] A1  = 26'h1357924;
  localparam logic [63:0] P1D = 64'hDEAD_BEEF_0BAD_F00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, init_done;
  logic        p0_cmd_valid, p1_cmd_valid;
  logic [3:0]  p0_cmd, p1_cmd;
  logic [25:0] p0_addr, p1_addr;
  logic [4:0]  p0_burst_cnt, p1_burst_cnt;
  logic [63:0] p0_write_data, p1_write_data;
  logic [7:0]  p0_data_mask, p1_data_mask;
  logic        p0_cmd_ack, p0_datain_rdy, p0_read_data_valid, p0_done;
  logic        p1_cmd_ack, p1_datain_rdy, p1_read_data_valid, p1_done;
  logic [63:0] p0_read_data, p1_read_data;
  logic        cmd_rdy, datain_rdy, read_data_valid;
  logic [63:0] read_data;
  logic        cmd_valid;
  logic [3:0]  cmd;
  logic [25:0] addr;
  logic [4:0]  cmd_burst_cnt;
  logic [63:0] write_data;
  logic [7:0]  data_mask;
  logic        grant, busy, timeout_err;

  ddr3_port_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .p0_cmd_valid(p0_cmd_valid), .p0_cmd(p0_cmd), .p0_addr(p0_addr),
    .p0_burst_cnt(p0_burst_cnt), .p0_write_data(p0_write_data), .p0_data_mask(p0_data_mask),
    .p0_cmd_ack(p0_cmd_ack), .p0_datain_rdy(p0_datain_rdy), .p0_read_data(p0_read_data),
    .p0_read_data_valid(p0_read_data_valid), .p0_done(p0_done),
    .p1_cmd_valid(p1_cmd_valid), .p1_cmd(p1_cmd), .p1_addr(p1_addr),
    .p1_burst_cnt(p1_burst_cnt), .p1_write_data(p1_write_data), .p1_data_mask(p1_data_mask),
    .p1_cmd_ack(p1_cmd_ack), .p1_datain_rdy(p1_datain_rdy), .p1_read_data(p1_read_data),
    .p1_read_data_valid(p1_read_data_valid), .p1_done(p1_done),
    .cmd_rdy(cmd_rdy), .datain_rdy(datain_rdy), .read_data_valid(read_data_valid),
    .read_data(read_data), .cmd_valid(cmd_valid), .cmd(cmd), .addr(addr),
    .cmd_burst_cnt(cmd_burst_cnt), .write_data(write_data), .data_mask(data_mask),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        init, p0v, crdy, drdy;
    logic [63:0] wd;
    logic        cv, ack0, drdy0, done0, bsy;
    logic [63:0] wdo;
  } wvec_t;

  wvec_t wv[13];

  task automatic wait_cmd(input logic g, input logic [3:0] c);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      seen = cmd_valid;
    end
    chk("cmd_valid_wait", 64'(seen), 64'd1);
    chk("grant", 64'(grant), 64'(g));
    chk("addr", 64'(addr), g ? 64'(A1) : 64'(A0));
    chk("cmd", 64'(cmd), 64'(c));
  endtask

  task automatic run_read(input logic g, input int words, input logic drop);
    int fwd;
    logic [63:0] rd;
    wait_cmd(g, 4'h1);
    @(negedge clk); #1;
    chk("ack_win", 64'(g ? p1_cmd_ack : p0_cmd_ack), 64'd1);
    chk("ack_lose", 64'(g ? p0_cmd_ack : p1_cmd_ack), 64'd0);
    if (drop) begin
      if (g) p1_cmd_valid = 1'b0;
      else   p0_cmd_valid = 1'b0;
    end
    fwd = 0;
    for (int k = 0; k < words; k++) begin
      @(negedge clk);
      rd = (g ? 64'hB1B1_0000_0000_0000 : 64'hB0B0_0000_0000_0000) | 64'(k);
      read_data_valid = 1'b1;
      read_data = rd;
      #1;
      if (g ? p1_read_data_valid : p0_read_data_valid) fwd++;
      chk("rd_other_port", 64'(g ? p0_read_data_valid : p1_read_data_valid), 64'd0);
      chk("rd_bcast", {p0_read_data ^ rd} | {p1_read_data ^ rd}, 64'd0);
    end
    chk("rd_words", 64'(fwd), 64'(words));
    @(negedge clk); read_data_valid = 1'b1; #1;
    chk("rd_done", 64'(g ? p1_done : p0_done), 64'd1);
    chk("rd_stray", 64'(p0_read_data_valid | p1_read_data_valid), 64'd0);
    @(negedge clk); read_data_valid = 1'b0; read_data = '0; #1;
    chk("rd_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int beats;
    for (int i = 0; i < 13; i++) begin
      wv[i] = '{init: 1'b1, p0v: 1'b0, crdy: 1'b1, drdy: 1'b0, wd: 64'd0,
                cv: 1'b0, ack0: 1'b0, drdy0: 1'b0, done0: 1'b0, bsy: 1'b1, wdo: 64'd0};
    end
    wv[0].p0v = 1'b1; wv[0].crdy = 1'b0; wv[0].bsy = 1'b0;
    wv[1].p0v = 1'b1; wv[1].cv = 1'b1;
    wv[2].ack0 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wv[3 + 2*b].wd  = 64'hA5A5_0000_0000_0001 + 64'(b);
      wv[3 + 2*b].wdo = 64'hA5A5_0000_0000_0001 + 64'(b);
      wv[4 + 2*b].wd  = 64'hA5A5_0000_0000_0001 + 64'(b);
      wv[4 + 2*b].wdo = 64'hA5A5_0000_0000_0001 + 64'(b);
      wv[4 + 2*b].drdy = 1'b1;
      wv[4 + 2*b].drdy0 = 1'b1;
    end
    wv[11].drdy = 1'b1; wv[11].done0 = 1'b1;
    wv[12].bsy = 1'b0;

    rst = 1'b1; init_done = 1'b0;
    p0_cmd_valid = 1'b0; p0_cmd = 4'h2; p0_addr = A0; p0_burst_cnt = 5'd4;
    p0_write_data = '0; p0_data_mask = 8'h0F;
    p1_cmd_valid = 1'b0; p1_cmd = 4'h1; p1_addr = A1; p1_burst_cnt = 5'd8;
    p1_write_data = P1D; p1_data_mask = 8'hF0;
    cmd_rdy = 1'b0; datain_rdy = 1'b0; read_data_valid = 1'b0; read_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 64'({cmd_valid, p0_cmd_ack, p1_cmd_ack, p0_datain_rdy, p1_datain_rdy,
                           p0_done, p1_done, p0_read_data_valid, p1_read_data_valid,
                           grant, busy, timeout_err}), 64'd0);
    chk("reset_cmd", 64'({cmd, addr, cmd_burst_cnt}), 64'd0);
    chk("reset_wdata", write_data, 64'd0);

    // init_done low blocks arbitration
    @(negedge clk); rst = 1'b0; p0_cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("init_gate_cv", 64'(cmd_valid), 64'd0);
    end

    beats = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      init_done = wv[i].init; p0_cmd_valid = wv[i].p0v; cmd_rdy = wv[i].crdy;
      datain_rdy = wv[i].drdy; p0_write_data = wv[i].wd;
      #1;
      chk($sformatf("wr_cv[%0d]", i), 64'(cmd_valid), 64'(wv[i].cv));
      chk($sformatf("wr_ack0[%0d]", i), 64'(p0_cmd_ack), 64'(wv[i].ack0));
      chk($sformatf("wr_drdy0[%0d]", i), 64'(p0_datain_rdy), 64'(wv[i].drdy0));
      chk($sformatf("wr_done0[%0d]", i), 64'(p0_done), 64'(wv[i].done0));
      chk($sformatf("wr_busy[%0d]", i), 64'(busy), 64'(wv[i].bsy));
      chk($sformatf("wr_data[%0d]", i), write_data, wv[i].wdo);
      chk($sformatf("wr_mask[%0d]", i), 64'(data_mask), (wv[i].wdo != 0) ? 64'h0F : 64'h0);
      chk($sformatf("wr_p1_quiet[%0d]", i),
          64'({p1_cmd_ack, p1_datain_rdy, p1_done, p1_read_data_valid}), 64'd0);
      if (wv[i].cv) begin
        chk("wr_addr", 64'(addr), 64'(A0));
        chk("wr_burst", 64'(cmd_burst_cnt), 64'd4);
        chk("wr_grant", 64'(grant), 64'd0);
      end
      if (p0_datain_rdy) beats++;
    end
    chk("wr_beats", 64'(beats), 64'd4);

    // Fresh pointer, both ports read twice: grants 0,1,0,1
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    p0_cmd = 4'h1; p0_burst_cnt = 5'd8; p1_cmd = 4'h1; p1_burst_cnt = 5'd8;
    p0_cmd_valid = 1'b1; p1_cmd_valid = 1'b1; cmd_rdy = 1'b1; datain_rdy = 1'b0;
    run_read(1'b0, 8, 1'b0);
    run_read(1'b1, 8, 1'b0);
    run_read(1'b0, 8, 1'b1);
    run_read(1'b1, 8, 1'b1);

    // Burst count 0 carries 32 words
    @(negedge clk); p0_burst_cnt = 5'd0; p0_cmd_valid = 1'b1;
    run_read(1'b0, 32, 1'b1);

    // Watchdog: only 2 of 4 words come back
    @(negedge clk); p0_burst_cnt = 5'd4; p0_cmd_valid = 1'b1;
    wait_cmd(1'b0, 4'h1);
    @(negedge clk); #1;
    chk("to_ack0", 64'(p0_cmd_ack), 64'd1);
    p0_cmd_valid = 1'b0;
    p1_cmd = 4'h6; p1_burst_cnt = 5'd3; p1_cmd_valid = 1'b1;
    repeat (2) begin
      @(negedge clk); read_data_valid = 1'b1; read_data = 64'h77;
    end
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk); read_data_valid = 1'b0; read_data = '0; #1;
      if (j == 15) begin
        chk("to_err_early", 64'(timeout_err), 64'd0);
        chk("to_busy_early", 64'(busy), 64'd1);
      end
      if (j == 16) begin
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_done0", 64'(p0_done), 64'd1);
      end
      if (j == 17) begin
        chk("to_idle", 64'(busy), 64'd0);
        chk("to_sticky", 64'(timeout_err), 64'd1);
      end
      if (j == 18) begin
        chk("ctl_cv", 64'(cmd_valid), 64'd1);
        chk("ctl_grant", 64'(grant), 64'd1);
        chk("ctl_cmd", 64'(cmd), 64'h6);
      end
      if (j == 19) begin
        chk("ctl_ack1", 64'(p1_cmd_ack), 64'd1);
        chk("ctl_cv_drop", 64'(cmd_valid), 64'd0);
        p1_cmd_valid = 1'b0;
      end
      if (j == 20) chk("ctl_done1", 64'(p1_done), 64'd1);
      if (j == 21) chk("ctl_idle", 64'(busy), 64'd0);
    end

    // Reset in the middle of a write burst
    @(negedge clk);
    p0_cmd = 4'h2; p0_burst_cnt = 5'd4; p0_write_data = 64'h1234_5678_9ABC_DEF0;
    p0_cmd_valid = 1'b1; datain_rdy = 1'b1;
    wait_cmd(1'b0, 4'h2);
    @(negedge clk); #1;
    chk("rw_ack0", 64'(p0_cmd_ack), 64'd1);
    p0_cmd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rw_beat", 64'(p0_datain_rdy), 64'd1);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rw_reset_ctrl", 64'({cmd_valid, p0_cmd_ack, p1_cmd_ack, p0_datain_rdy, p1_datain_rdy,
                              p0_done, p1_done, p0_read_data_valid, p1_read_data_valid,
                              grant, busy, timeout_err}), 64'd0);
    chk("rw_reset_cmd", 64'({cmd, addr, cmd_burst_cnt}), 64'd0);
    chk("rw_reset_wdata", write_data, 64'd0);
    chk("rw_reset_mask", 64'(data_mask), 64'd0);
    p1_cmd = 4'h2; p1_burst_cnt = 5'd1; p1_cmd_valid = 1'b1;
    wait_cmd(1'b1, 4'h2);
    @(negedge clk); #1;
    chk("rw_ack1", 64'(p1_cmd_ack), 64'd1);
    p1_cmd_valid = 1'b0;
    @(negedge clk); #1;
    chk("rw_p1_beat", 64'(p1_datain_rdy), 64'd1);
    chk("rw_p0_quiet", 64'(p0_datain_rdy), 64'd0);
    chk("rw_p1_data", write_data, P1D);
    chk("rw_p1_mask", 64'(data_mask), 64'hF0);
    @(negedge clk); #1;
    chk("rw_done1", 64'(p1_done), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
